// File: rtl/pp_row_accumulator.sv
// pp_row_accumulator: sums R pre-shifted partial-product rows per clock into a 2N-bit product (clk, rst, start, pp in; busy, done, product out)
module pp_row_accumulator #(
  parameter int N = 92,
  parameter int R = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*N*N-1:0]   pp,
  output logic               busy,
  output logic               done,
  output logic [2*N-1:0]     product
);
  localparam int W = $clog2(N + R);
  localparam logic [W-1:0] RW = W'(R);
  localparam logic [W-1:0] NW = W'(N);
  typedef enum logic {IDLE, ACC} state_t;
  state_t state, state_nx;
  logic [2*N-1:0] acc, sum;
  logic [W-1:0] row_idx;
  logic last;
  logic [2*N-1:0] rows [N+R];
  genvar g;
  for (g = 0; g < N + R; g++) begin : gr
    if (g < N) begin : r
      assign rows[g] = pp[g*2*N +: 2*N];
    end else begin : z
      assign rows[g] = '0;
    end
  end
  always_comb begin
    sum = acc;
    for (int k = 0; k < R; k++) sum = sum + rows[row_idx + W'(k)];
    last = row_idx + RW >= NW;
    state_nx = state == IDLE ? (start ? ACC : IDLE) : (last ? IDLE : ACC);
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      row_idx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      product <= '0;
    end else if (state == IDLE) begin
      done <= 1'b0;
      busy <= start;
      if (start) begin
        acc <= '0;
        row_idx <= '0;
      end
    end else begin
      acc <= sum;
      row_idx <= row_idx + RW;
      done <= last;
      busy <= !last;
      if (last) product <= sum;
    end
  end
  pp_stable: assert property (@(posedge clk) disable iff (rst) busy && $past(busy) |-> pp == $past(pp));
endmodule

// File: tb/tb_pp_row_accumulator.sv
// tb_pp_row_accumulator: directed scoreboard bench for R=4 and R=5 builds of pp_row_accumulator
module tb_pp_row_accumulator;
  localparam int N = 92;
  typedef struct {logic [2*N-1:0] p; int t;} exp_t;
  logic clk = 0, rst = 1, start4 = 0, start5 = 0;
  logic [2*N*N-1:0] pp = '0;
  logic busy4, done4, busy5, done5;
  logic [2*N-1:0] product4, product5, h4 = '0, h5 = '0;
  exp_t q4[$], q5[$];
  exp_t e;
  int cyc = 0, total = 0, bad = 0;
  pp_row_accumulator #(.N(N), .R(4)) u4 (.clk(clk), .rst(rst), .start(start4), .pp(pp), .busy(busy4), .done(done4), .product(product4));
  pp_row_accumulator #(.N(N), .R(5)) u5 (.clk(clk), .rst(rst), .start(start5), .pp(pp), .busy(busy5), .done(done5), .product(product5));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [2*N-1:0] act, input logic [2*N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", n, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  function automatic logic [2*N*N-1:0] build(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N*N-1:0] m = '0;
    for (int i = 0; i < N; i++) if (b[i]) m[i*2*N +: 2*N] = {{N{1'b0}}, a} << i;
    return m;
  endfunction
  task automatic wait_empty();
    for (int i = 0; i < 80 && (q4.size() + q5.size()) != 0; i++) tick();
    chk("timeout", 184'(q4.size() + q5.size()), '0);
  endtask
  task automatic go(input bit five, input logic [N-1:0] a, input logic [N-1:0] b, input logic [2*N-1:0] ex);
    pp = build(a, b);
    if (five) begin
      start5 = 1;
      q5.push_back('{ex, cyc + 1 + 19});
    end else begin
      start4 = 1;
      q4.push_back('{ex, cyc + 1 + 23});
    end
    tick();
    start4 = 0;
    start5 = 0;
    wait_empty();
  endtask
  always @(negedge clk) begin
    if (rst) begin
      h4 = '0;
      h5 = '0;
      q4.delete();
      q5.delete();
    end else begin
      if (done4) begin
        if (q4.size() == 0) chk("r4_spurious_done", 184'(q4.size()), 184'd1);
        else begin
          e = q4.pop_front();
          chk("r4_product", product4, e.p);
          chk("r4_latency", 184'(cyc), 184'(e.t));
          chk("r4_busy_at_done", 184'(busy4), '0);
          h4 = e.p;
        end
      end else chk("r4_hold", product4, h4);
      if (done5) begin
        if (q5.size() == 0) chk("r5_spurious_done", 184'(q5.size()), 184'd1);
        else begin
          e = q5.pop_front();
          chk("r5_product", product5, e.p);
          chk("r5_latency", 184'(cyc), 184'(e.t));
          chk("r5_busy_at_done", 184'(busy5), '0);
          h5 = e.p;
        end
      end else chk("r5_hold", product5, h5);
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end
  initial begin
    logic [N-1:0] ones, top, a, b;
    logic [2*N-1:0] k1, p91, p182;
    logic [95:0] r;
    int c;
    ones = '1;
    top = '0;
    top[N-1] = 1'b1;
    k1 = 184'hFFFF_FFFF_FFFF_FFFF_FFFF_FF_E_0000_0000_0000_0000_0000_00_1;
    p91 = 184'd1 << 91;
    p182 = 184'd1 << 182;
    repeat (3) tick();
    chk("rst_busy4", 184'(busy4), '0);
    chk("rst_done4", 184'(done4), '0);
    chk("rst_product4", product4, '0);
    chk("rst_busy5", 184'(busy5), '0);
    chk("rst_product5", product5, '0);
    rst = 0;
    tick();
    go(0, ones, ones, k1);
    go(0, 92'h3, 92'h5, 184'hF);
    go(0, 92'hABCDEF, '0, '0);
    go(0, '0, ones, '0);
    go(0, 92'h1, top, p91);
    go(0, top, top, p182);
    go(1, top, top, p182);
    go(1, ones, ones, k1);
    go(1, 92'h3, 92'h5, 184'hF);
    c = cyc;
    pp = build(92'h1234_5678, 92'hFEDC_BA98);
    start4 = 1;
    for (int i = 1; i <= 3; i++) q4.push_back('{184'h1234_5678 * 184'hFEDC_BA98, c + 24 * i});
    for (int i = 0; i < 100 && cyc < c + 72; i++) tick();
    start4 = 0;
    wait_empty();
    c = cyc;
    pp = build(92'h77, 92'h99);
    start4 = 1;
    q4.push_back('{184'h77 * 184'h99, c + 24});
    tick();
    start4 = 0;
    repeat (5) tick();
    start4 = 1;
    tick();
    start4 = 0;
    chk("busy_after_ignored_start", 184'(busy4), 184'd1);
    wait_empty();
    repeat (30) tick();
    c = cyc;
    pp = build(ones, ones);
    start4 = 1;
    q4.push_back('{k1, c + 24});
    tick();
    start4 = 0;
    repeat (9) tick();
    rst = 1;
    tick();
    chk("midrst_busy", 184'(busy4), '0);
    chk("midrst_done", 184'(done4), '0);
    chk("midrst_product", product4, '0);
    rst = 0;
    repeat (30) tick();
    go(0, 92'h3, 92'h5, 184'hF);
    for (int i = 0; i < 40; i++) begin
      r = {$urandom, $urandom, $urandom};
      a = r[N-1:0];
      r = {$urandom, $urandom, $urandom};
      b = r[N-1:0];
      go(i % 4 == 3, a, b, {{N{1'b0}}, a} * {{N{1'b0}}, b});
    end
    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
